// File: rtl/aes_pkg.sv
// Shared AES definitions: sizes, round counts, reduction constant,
// inverse S-box and the xtime helper used by the inverse round.
package aes_pkg;

    localparam int STATE_W = 128;

    // Round counts for the three key sizes.
    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;

    // Low byte of the GF(2^8) reduction polynomial x^8+x^4+x^3+x+1.
    localparam logic [7:0] RED_POLY = 8'h1b;

    // Controller states of the iterative inverse cipher.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_FINAL,
        ST_DONE
    } inv_state_e;

    // Inverse S-box, indexed by the input byte.
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Multiply by x in GF(2^8).
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RED_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/inv_std_round.sv
// One combinational AES inverse round. Byte k of the state sits at bits
// [8k:8k+7], row = k%4, column = k/4. With final_i set the InvMixColumns
// step is skipped (last round of the inverse cipher).
module inv_std_round
    import aes_pkg::*;
(
    input  logic [0:STATE_W-1] state_i,
    input  logic [0:STATE_W-1] key_i,
    input  logic               final_i,
    output logic [0:STATE_W-1] state_o
);

    // Multiply by one of 0e/0b/0d/09; all four have the x^3 term, so only
    // the lower three coefficient bits select extra partial products.
    function automatic logic [7:0] gf_mul_inv(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ (c[2] ? x4 : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[0] ? a : 8'h00);
    endfunction

    logic [7:0] sub_b [16];
    logic [7:0] ark_b [16];
    logic [7:0] mix_b [16];

    genvar gi, gr;

    // InvShiftRows (row r rotated right by r) fused with InvSubBytes and AddRoundKey.
    generate
        for (gi = 0; gi < 16; gi++) begin : g_byte
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
            assign sub_b[gi] = INV_SBOX[state_i[8*SRC +: 8]];
            assign ark_b[gi] = sub_b[gi] ^ key_i[8*gi +: 8];
            assign state_o[8*gi +: 8] = final_i ? ark_b[gi] : mix_b[gi];
        end
    endgenerate

    // InvMixColumns: each output row uses the 0e,0b,0d,09 vector rotated by the row.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            for (gr = 0; gr < 4; gr++) begin : g_row
                assign mix_b[4*gi + gr] =
                      gf_mul_inv(ark_b[4*gi + gr],           4'he)
                    ^ gf_mul_inv(ark_b[4*gi + (gr + 1) % 4], 4'hb)
                    ^ gf_mul_inv(ark_b[4*gi + (gr + 2) % 4], 4'hd)
                    ^ gf_mul_inv(ark_b[4*gi + (gr + 3) % 4], 4'h9);
            end
        end
    endgenerate

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one inverse round per enabled clock, round
// keys fetched from an external key store by index (combinational return).
module aes_inv_cipher_iter
    import aes_pkg::*;
#(
    parameter int NR = NR_AES128
)
(
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iEn,
    input  logic               iStart,
    input  logic [0:STATE_W-1] iState,
    input  logic [0:STATE_W-1] iKey,
    output logic [3:0]         oKey_idx,
    output logic [0:STATE_W-1] oState,
    output logic               oReady,
    output logic               oDone
);

    generate
        if (NR != NR_AES128 && NR != NR_AES192 && NR != NR_AES256) begin : g_bad_nr
            $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
        end
    endgenerate

    localparam logic [3:0] NR_IDX = 4'(NR);
    localparam logic [3:0] NR_M1  = 4'(NR - 1);

    inv_state_e         fsm_q, fsm_d;
    logic [0:STATE_W-1] rstate_q, rstate_d;
    logic [3:0]         round_q, round_d;
    logic [3:0]         key_idx_q, key_idx_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic [0:STATE_W-1] round_out;

    inv_std_round u_round (
        .state_i (rstate_q),
        .key_i   (iKey),
        .final_i (fsm_q == ST_FINAL),
        .state_o (round_out)
    );

    // Next-state logic; outputs are derived from the next state so they register cleanly.
    always_comb begin
        fsm_d     = fsm_q;
        rstate_d  = rstate_q;
        round_d   = round_q;
        key_idx_d = key_idx_q;
        ready_d   = ready_q;
        done_d    = done_q;
        if (iEn) begin
            done_d = 1'b0;
            case (fsm_q)
                ST_IDLE, ST_DONE: begin
                    if (iStart && ready_q) begin
                        rstate_d = iState ^ iKey;
                        round_d  = NR_M1;
                        fsm_d    = (NR_M1 == 4'd0) ? ST_FINAL : ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    rstate_d = round_out;
                    round_d  = round_q - 4'd1;
                    if (round_q == 4'd1) begin
                        fsm_d = ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    rstate_d = round_out;
                    fsm_d    = ST_DONE;
                    done_d   = 1'b1;
                end
                default: fsm_d = ST_IDLE;
            endcase
            ready_d = (fsm_d == ST_IDLE) || (fsm_d == ST_DONE);
            case (fsm_d)
                ST_ROUND: key_idx_d = round_d;
                ST_FINAL: key_idx_d = 4'd0;
                default:  key_idx_d = NR_IDX;
            endcase
        end
    end

    // Single state register for FSM, datapath and registered outputs.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            fsm_q     <= ST_IDLE;
            rstate_q  <= '0;
            round_q   <= '0;
            key_idx_q <= NR_IDX;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            rstate_q  <= rstate_d;
            round_q   <= round_d;
            key_idx_q <= key_idx_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
        end
    end

    assign oState   = rstate_q;
    assign oKey_idx = key_idx_q;
    assign oReady   = ready_q;
    assign oDone    = done_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: FIPS-197 vectors, stall, reset, busy start
// and random blocks against a byte-matrix model of the inverse cipher.
module tb_aes_inv_cipher_iter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b1;
    logic         start_a = 1'b0;
    logic         start_b = 1'b0;
    logic [0:127] st_in = '0;
    logic [0:127] key_a, key_b, out_a, out_b;
    logic [3:0]   kidx_a, kidx_b;
    logic         rdy_a, rdy_b, done_a, done_b;
    logic [0:127] rk_a [15];
    logic [0:127] rk_b [15];
    logic [7:0]   sbox [256];
    logic [7:0]   inv_sbox [256];
    int           checks = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    assign key_a = rk_a[kidx_a];
    assign key_b = rk_b[kidx_b];

    aes_inv_cipher_iter #(.NR(10)) dut_a (
        .iClk(clk), .iRst(rst), .iEn(en), .iStart(start_a), .iState(st_in), .iKey(key_a),
        .oKey_idx(kidx_a), .oState(out_a), .oReady(rdy_a), .oDone(done_a)
    );

    aes_inv_cipher_iter #(.NR(14)) dut_b (
        .iClk(clk), .iRst(rst), .iEn(en), .iStart(start_b), .iState(st_in), .iKey(key_b),
        .oKey_idx(kidx_b), .oState(out_b), .oReady(rdy_b), .oDone(done_b)
    );

    localparam logic [0:255] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [0:255] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [0:255] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [0:127] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [0:127] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] R0_C1  = 128'h7ad5fda789ef4e272bca100b3d9ff59f;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_sboxes();
        logic [7:0] inv, t, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            t = inv;
            s = inv;
            for (int k = 0; k < 4; k++) begin
                t = {t[6:0], t[7]};
                s = s ^ t;
            end
            s = s ^ 8'h63;
            sbox[x] = s;
            inv_sbox[s] = 8'(x);
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic logic [0:127] round_key(input logic [0:255] key, input int nr, input int r);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nk;
        nk = nr - 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [0:127] ref_decrypt(input logic [0:127] ct, input logic [0:255] key, input int nr);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   m [4];
        logic [7:0]   acc;
        logic [0:127] rk, res;
        m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        rk = round_key(key, nr, nr);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) s[r][c] = ct[8*(r+4*c) +: 8] ^ rk[8*(r+4*c) +: 8];
        for (int rnd = nr - 1; rnd >= 0; rnd--) begin
            rk = round_key(key, nr, rnd);
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = inv_sbox[s[r][(c - r + 4) % 4]] ^ rk[8*(r+4*c) +: 8];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    acc = 8'h00;
                    for (int j = 0; j < 4; j++) acc = acc ^ gmul(m[(j - r + 4) % 4], t[j][c]);
                    s[r][c] = (rnd > 0) ? acc : t[r][c];
                end
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) res[8*(r+4*c) +: 8] = s[r][c];
        return res;
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_key_a(input logic [0:255] k);
        for (int r = 0; r <= 10; r++) rk_a[r] = round_key(k, 10, r);
    endtask

    task automatic load_key_b(input logic [0:255] k);
        for (int r = 0; r <= 14; r++) rk_b[r] = round_key(k, 14, r);
    endtask

    task automatic accept_a(input logic [0:127] ct);
        st_in = ct;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    // Counts edges from the accepting edge until oDone; n=limit means timeout.
    task automatic wait_done_a(input int first, input int limit, output int n);
        n = first;
        while (!done_a && n < limit) begin
            tick();
            n++;
        end
        if (!done_a) n = limit;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; en = 1'b1; start_a = 1'b1; start_b = 1'b1; st_in = CT_C1;
        tick(); tick();
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
        checks++; if (out_a !== 128'h0) begin failures++; $display("FAIL reset_state got=%h exp=0", out_a); end
        checks++; if (rdy_a !== 1'b1 || done_a !== 1'b0) begin failures++; $display("FAIL reset_flags ready=%b done=%b exp ready=1 done=0", rdy_a, done_a); end
        checks++; if (kidx_a !== 4'd10) begin failures++; $display("FAIL reset_kidx_a got=%0d exp=10", kidx_a); end
        checks++; if (kidx_b !== 4'd14) begin failures++; $display("FAIL reset_kidx_b got=%0d exp=14", kidx_b); end
        $display("reset: out=%h ready=%b done=%b kidx_a=%0d kidx_b=%0d", out_a, rdy_a, done_a, kidx_a, kidx_b);
    endtask

    task automatic test_fips_c1();
        int n;
        load_key_a(KEY_C1);
        accept_a(CT_C1);
        checks++; if (out_a !== R0_C1) begin failures++; $display("FAIL c1_first_round got=%h exp=%h", out_a, R0_C1); end
        wait_done_a(1, 40, n);
        checks++; if (n !== 11) begin failures++; $display("FAIL c1_latency got=%0d exp=11", n); end
        checks++; if (out_a !== PT_C) begin failures++; $display("FAIL c1_result got=%h exp=%h", out_a, PT_C); end
        $display("c1: latency=%0d out=%h", n, out_a);
    endtask

    // Starts the App. B block in the oDone cycle left by the previous test.
    task automatic test_back_to_back();
        int n;
        checks++; if (done_a !== 1'b1 || rdy_a !== 1'b1) begin failures++; $display("FAIL b2b_entry done=%b ready=%b exp 1 1", done_a, rdy_a); end
        load_key_a(KEY_B);
        accept_a(CT_B);
        checks++; if (done_a !== 1'b0 || rdy_a !== 1'b0) begin failures++; $display("FAIL b2b_pulse_end done=%b ready=%b exp 0 0", done_a, rdy_a); end
        wait_done_a(1, 40, n);
        checks++; if (n !== 11) begin failures++; $display("FAIL b2b_latency got=%0d exp=11", n); end
        checks++; if (out_a !== PT_B) begin failures++; $display("FAIL b2b_result got=%h exp=%h", out_a, PT_B); end
        $display("b2b: latency=%0d out=%h", n, out_a);
        tick();
    endtask

    task automatic test_nr14();
        logic [0:127] exp_pt;
        load_key_b(KEY_C3);
        exp_pt = ref_decrypt(CT_C3, KEY_C3, 14);
        st_in = CT_C3;
        start_b = 1'b1;
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (kidx_b !== 4'(14 - i) || done_b !== 1'b0) begin
                failures++;
                $display("FAIL nr14_kidx step=%0d got=%0d done=%b exp=%0d done=0", i, kidx_b, done_b, 14 - i);
            end
            tick();
            start_b = 1'b0;
        end
        checks++; if (done_b !== 1'b1) begin failures++; $display("FAIL nr14_latency done=%b exp=1 after 15 edges", done_b); end
        checks++; if (out_b !== PT_C) begin failures++; $display("FAIL nr14_result got=%h exp=%h", out_b, PT_C); end
        checks++; if (out_b !== exp_pt) begin failures++; $display("FAIL nr14_model got=%h exp=%h", out_b, exp_pt); end
        $display("nr14: out=%h", out_b);
        tick();
    endtask

    task automatic test_stall();
        int n;
        logic [0:127] held;
        logic [3:0]   held_idx;
        load_key_a(KEY_C1);
        accept_a(CT_C1);
        for (int i = 0; i < 4; i++) tick();
        held = out_a;
        held_idx = kidx_a;
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_a !== held || kidx_a !== held_idx || rdy_a !== 1'b0 || done_a !== 1'b0) begin
                failures++;
                $display("FAIL stall_frozen cyc=%0d out=%h idx=%0d rdy=%b done=%b exp out=%h idx=%0d rdy=0 done=0",
                         i, out_a, kidx_a, rdy_a, done_a, held, held_idx);
            end
        end
        en = 1'b1;
        wait_done_a(8, 50, n);
        checks++; if (n !== 14) begin failures++; $display("FAIL stall_latency got=%0d exp=14", n); end
        checks++; if (out_a !== PT_C) begin failures++; $display("FAIL stall_result got=%h exp=%h", out_a, PT_C); end
        $display("stall: latency=%0d out=%h", n, out_a);
        tick();
    endtask

    task automatic test_reset_mid();
        int n;
        int pulses;
        load_key_a(KEY_C1);
        accept_a(CT_C1);
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (out_a !== 128'h0 || rdy_a !== 1'b1 || done_a !== 1'b0) begin
            failures++; $display("FAIL rst_mid_state out=%h rdy=%b done=%b exp 0 1 0", out_a, rdy_a, done_a);
        end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done_a) pulses++;
            tick();
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL rst_mid_no_done got=%0d exp=0", pulses); end
        accept_a(CT_C1);
        wait_done_a(1, 40, n);
        checks++; if (n !== 11 || out_a !== PT_C) begin failures++; $display("FAIL rst_mid_fresh lat=%0d out=%h exp 11 %h", n, out_a, PT_C); end
        $display("reset_mid: fresh latency=%0d out=%h", n, out_a);
        tick();
    endtask

    task automatic test_busy_start();
        int first;
        int pulses;
        logic [0:127] got;
        load_key_a(KEY_C1);
        accept_a(CT_C1);
        first = 0; pulses = 0; got = '0;
        for (int i = 1; i < 30; i++) begin
            if (i == 3) begin st_in = {$urandom, $urandom, $urandom, $urandom}; start_a = 1'b1; end
            if (i == 5) start_a = 1'b0;
            if (done_a) begin
                pulses++;
                if (first == 0) begin first = i; got = out_a; end
            end
            tick();
        end
        checks++; if (pulses !== 1 || first !== 11) begin failures++; $display("FAIL busy_done pulses=%0d at=%0d exp 1 at 11", pulses, first); end
        checks++; if (got !== PT_C || out_a !== PT_C) begin failures++; $display("FAIL busy_result got=%h now=%h exp=%h", got, out_a, PT_C); end
        $display("busy_start: pulses=%0d at=%0d out=%h", pulses, first, got);
    endtask

    task automatic test_random();
        int n;
        logic [0:255] k;
        logic [0:127] ct, exp_pt;
        for (int t = 0; t < 6; t++) begin
            k = {$urandom, $urandom, $urandom, $urandom, 128'h0};
            ct = {$urandom, $urandom, $urandom, $urandom};
            exp_pt = ref_decrypt(ct, k, 10);
            load_key_a(k);
            accept_a(ct);
            wait_done_a(1, 40, n);
            checks++;
            if (n !== 11 || out_a !== exp_pt) begin
                failures++;
                $display("FAIL rand128 t=%0d lat=%0d got=%h exp=%h", t, n, out_a, exp_pt);
            end
            $display("rand128 t=%0d ct=%h out=%h", t, ct, out_a);
        end
        for (int t = 0; t < 3; t++) begin
            k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            ct = {$urandom, $urandom, $urandom, $urandom};
            exp_pt = ref_decrypt(ct, k, 14);
            load_key_b(k);
            st_in = ct;
            start_b = 1'b1;
            tick();
            start_b = 1'b0;
            n = 1;
            while (!done_b && n < 40) begin tick(); n++; end
            checks++;
            if (n !== 15 || done_b !== 1'b1 || out_b !== exp_pt) begin
                failures++;
                $display("FAIL rand256 t=%0d lat=%0d got=%h exp=%h", t, n, out_b, exp_pt);
            end
            $display("rand256 t=%0d ct=%h out=%h", t, ct, out_b);
        end
    endtask

    initial begin
        build_sboxes();
        @(negedge clk);
        test_reset();
        test_fips_c1();
        test_back_to_back();
        test_nr14();
        test_stall();
        test_reset_mid();
        test_busy_start();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_inv_cipher_iter.md
Name: aes_inv_cipher_iter

Overview:
Iterative AES inverse cipher. Decrypts one 128-bit block using one inverse round per enabled clock. Round keys come from an external key store through an index/key lookup interface. It is the decryption counterpart of the encryption round datapath and sits beside it in the AES core, sharing the same key-store format and bit ordering: bits [0:7] are byte 0, stored column-major per FIPS-197.

Parameters:
NR, 10, number of rounds (10, 12 or 14 for AES-128/192/256); any other value is illegal.

Ports:
iClk  input  1  clock; all logic on rising edge
iRst  input  1  synchronous, active-high reset
iEn  input  1  global enable; low freezes all registers and the FSM
iStart  input  1  accept request; the block is taken when iStart & oReady & iEn
iState  input  [0:127]  ciphertext, sampled on accept
iKey  input  [0:127]  round key selected by oKey_idx, same cycle (combinational return)
oKey_idx  output  4  round-key index requested this cycle
oState  output  [0:127]  plaintext, valid from oDone until the next accept
oReady  output  1  high in IDLE and DONE
oDone  output  1  one-cycle completion pulse

Behaviour:
- Reset: FSM=IDLE, rState=0, rRound=0, oDone=0, oReady=1, oKey_idx=NR. Reset wins over iEn and iStart. Reset mid-decrypt aborts the block and produces no oDone.
- FSM states: IDLE, ROUND, FINAL, DONE. All transitions require iEn=1; with iEn=0 every register holds and oDone holds its value.
- IDLE/DONE + accept: rState <= iState ^ iKey with oKey_idx=NR; rRound <= NR-1; go to ROUND, or to FINAL if NR-1 == 0 (not reachable for legal NR).
- ROUND, oKey_idx=rRound: rState <= InvMixColumns(InvSubBytes(InvShiftRows(rState)) ^ iKey); rRound decrements; when rRound==1 go to FINAL.
- FINAL, oKey_idx=0: rState <= InvSubBytes(InvShiftRows(rState)) ^ iKey; go to DONE; oDone=1 for exactly one enabled cycle.
- DONE: oDone returns to 0 on the next enabled cycle. oState holds the result. The block is ready again; an accept in the same cycle as the oDone pulse is legal and starts a new block immediately (back-to-back).
- Latency: NR+1 enabled cycles from accept to oDone, i.e. 11, 13 or 15.
- iStart with oReady=0 is ignored and not queued.
- oKey_idx in IDLE/DONE is NR, so the store can pre-present the last key.
- InvMixColumns uses GF(2^8) multiplies by 0e, 0b, 0d, 09 with reduction polynomial 0x11b.
- InvShiftRows rotates row r right by r bytes.
- oState = rState directly; no output combinational path from iState.

Decomposition:
- Shared package aes_pkg: NR values (10/12/14), state width 128, reduction polynomial 8'h1b, inverse S-box table (256x8), xtime function.
- One sub-module, inv_std_round: combinational; inputs state, key and a final flag; output is the next state.
- The FSM and round counter stay in aes_inv_cipher_iter.

Test Plan:
- AES-128 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, iState 69c4e0d86a7b0430d8cdb78070b4c55a -> oDone 11 cycles after accept, oState 00112233445566778899aabbccddeeff. Also check rState = 7ad5fda789ef4e272bca100b3d9ff59f after the first cycle (rk10 = 13111d7fe3944a17f307a78b4d2b30c5).
- AES-128 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, iState 3925841d02dc09fbdc118597196a0b32 -> oState 3243f6a8885a308d313198a2e0370734. Issue this accept in the oDone cycle of the previous test; no idle cycle is permitted.
- NR=14, key 000102...1e1f, iState 8ea2b7ca516745bfeafc49904b496089 -> oState 00112233445566778899aabbccddeeff after 15 cycles; oKey_idx sequence 14,13,...,1,0.
- Stall: drop iEn for 3 cycles at round 5 of the C.1 vector -> rState, oKey_idx and FSM frozen; result identical, oDone delayed by 3 cycles.
- Reset mid-operation: assert iRst at round 4 -> next cycle oState=0, oReady=1, oDone stays 0; a fresh C.1 decryption then succeeds.
- iStart pulsed while busy -> ignored; oState unchanged, exactly one oDone.
